// File: rtl/onehot_decoder_pkg.sv
// ============================================================================
// Module      : onehot_decoder_pkg
// Description : Shared types and the one-hot helper for onehot_decoder_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package onehot_decoder_pkg;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // Returns 1<<sel at the widest supported size; callers cast down to OUT_W.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_OUT_W-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_decoder_seq_dwell_counter.sv
// ============================================================================
// Module      : dwell_counter
// Description : Free-running dwell counter; tick marks the last dwell cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dwell_counter #(
    parameter int CNT_W = 16,
    parameter int DWELL = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == C_LAST);
    assign tick      = run & w_at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_at_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/onehot_decoder_seq.sv
// ============================================================================
// Module      : onehot_decoder_seq
// Description : Registered N-to-2^N one-hot decoder with DIRECT and SCAN modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_decoder_seq
    import onehot_decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DWELL = 100,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    start,
    input  logic                    wrap,
    input  logic                    in_valid,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    in_ready,
    output logic [(1<<SEL_W)-1:0]   out_onehot,
    output logic [SEL_W-1:0]        out_idx,
    output logic                    out_valid,
    output logic                    scan_done
);

    localparam int OUT_W = 1 << SEL_W;
    localparam logic [SEL_W-1:0] C_LAST_IDX = SEL_W'(OUT_W - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [SEL_W-1:0]   r_idx;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [OUT_W-1:0]   r_onehot;

    mode_e              w_mode;
    logic               w_idle;
    logic               w_accept;
    logic               w_start;
    logic               w_tick;
    logic               w_cnt_clr;
    logic               w_cnt_run;

    assign w_mode   = mode_e'(mode);
    assign w_idle   = (r_state == ST_IDLE);
    assign in_ready = en & w_idle & (w_mode == MODE_DIRECT);
    assign w_accept = in_valid & in_ready;
    assign w_start  = en & w_idle & (w_mode == MODE_SCAN) & start;

    // Counter sits at zero outside SCAN, so each scan begins with a full dwell.
    assign w_cnt_clr = ~en | w_idle;
    assign w_cnt_run = en & (r_state == ST_SCAN);

    dwell_counter #(
        .CNT_W (CNT_W),
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_cnt_clr),
        .run   (w_cnt_run),
        .tick  (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_done_nxt  = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        w_state_nxt = ST_SCAN;
                        w_idx_nxt   = '0;
                        w_valid_nxt = 1'b1;
                    end else if (w_accept) begin
                        w_idx_nxt   = in_sel;
                        w_valid_nxt = 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (w_tick) begin
                        if (r_idx != C_LAST_IDX) begin
                            w_idx_nxt = r_idx + SEL_W'(1);
                        end else if (wrap) begin
                            w_idx_nxt = '0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_idx_nxt   = '0;
                            w_valid_nxt = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // The one-hot vector is rebuilt from the next index so it can never disagree with out_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_onehot <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_valid  <= w_valid_nxt;
            r_done   <= w_done_nxt;
            r_onehot <= w_valid_nxt ? OUT_W'(onehot(MAX_SEL_W'(w_idx_nxt))) : '0;
        end
    end

    assign out_onehot = r_onehot;
    assign out_idx    = r_idx;
    assign out_valid  = r_valid;
    assign scan_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_onehot_decoder_seq.sv
// ============================================================================
// Module      : tb_onehot_decoder_seq
// Description : Directed self-checking bench for onehot_decoder_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_decoder_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, mode, start, wrap, in_valid;
    logic [2:0]  in_sel;
    logic        in_ready;
    logic [7:0]  out_onehot;
    logic [2:0]  out_idx;
    logic        out_valid, scan_done;

    logic        b_en, b_mode, b_start, b_wrap, b_in_valid;
    logic [3:0]  b_in_sel;
    logic        b_in_ready;
    logic [15:0] b_onehot;
    logic [3:0]  b_idx;
    logic        b_valid, b_done;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0]  exp8  [8]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [15:0] exp16 [16] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008,
                               16'h0010, 16'h0020, 16'h0040, 16'h0080,
                               16'h0100, 16'h0200, 16'h0400, 16'h0800,
                               16'h1000, 16'h2000, 16'h4000, 16'h8000};

    always #5 clk = ~clk;

    onehot_decoder_seq #(.SEL_W(3), .DWELL(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .start      (start),
        .wrap       (wrap),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out_onehot (out_onehot),
        .out_idx    (out_idx),
        .out_valid  (out_valid),
        .scan_done  (scan_done)
    );

    onehot_decoder_seq #(.SEL_W(4), .DWELL(1), .CNT_W(16)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (b_en),
        .mode       (b_mode),
        .start      (b_start),
        .wrap       (b_wrap),
        .in_valid   (b_in_valid),
        .in_sel     (b_in_sel),
        .in_ready   (b_in_ready),
        .out_onehot (b_onehot),
        .out_idx    (b_idx),
        .out_valid  (b_valid),
        .scan_done  (b_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; start = 1'b0; wrap = 1'b0;
        in_valid = 1'b0; in_sel = '0;
        b_en = 1'b0; b_mode = 1'b0; b_start = 1'b0; b_wrap = 1'b0;
        b_in_valid = 1'b0; b_in_sel = '0;
        step(); step();
        check("rst_onehot", 32'(out_onehot), 32'h0);
        check("rst_idx",    32'(out_idx),    32'h0);
        check("rst_valid",  32'(out_valid),  32'h0);
        check("rst_done",   32'(scan_done),  32'h0);
        rst_n = 1'b1;

        // DIRECT sweep, one accept per cycle
        en = 1'b1;
        #1;
        check("direct_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_sel   = 3'(i);
            step();
            check("direct_onehot", 32'(out_onehot), 32'(exp8[i]));
            check("direct_idx",    32'(out_idx),    32'(i));
            check("direct_valid",  32'(out_valid),  32'h1);
        end
        in_valid = 1'b0;
        step();
        check("direct_hold", 32'(out_onehot), 32'h80);

        // Non-wrapping scan; start and in_valid together with mode=1
        mode = 1'b1; start = 1'b1; wrap = 1'b0; in_valid = 1'b1; in_sel = 3'd3;
        #1;
        check("scan_ready_low", 32'(in_ready), 32'h0);
        step();
        start = 1'b0;
        for (int c = 0; c < 32; c++) begin
            check("scan_onehot", 32'(out_onehot), 32'(exp8[c/4]));
            check("scan_inv",    32'(out_valid),  32'(|out_onehot));
            check("scan_nodone", 32'(scan_done),  32'h0);
            step();
        end
        check("scan_end_onehot", 32'(out_onehot), 32'h0);
        check("scan_end_valid",  32'(out_valid),  32'h0);
        check("scan_done_pulse", 32'(scan_done),  32'h1);
        step();
        check("scan_done_clear", 32'(scan_done),  32'h0);
        check("mode1_no_decode", 32'(out_onehot), 32'h0);

        // Wrapping scan with ignored start/mode/in_valid in SCAN, then en=0
        in_valid = 1'b1; in_sel = 3'd7; wrap = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 36; c++) begin
            if (c == 9)  begin start = 1'b1; mode = 1'b0; end
            if (c == 11) begin start = 1'b0; mode = 1'b1; end
            if (c == 10) begin
                #1;
                check("scan_ready_mode0", 32'(in_ready), 32'h0);
            end
            check("wrap_onehot", 32'(out_onehot), 32'(exp8[(c/4)%8]));
            check("wrap_nodone", 32'(scan_done),  32'h0);
            step();
        end
        en = 1'b0;
        step();
        check("en0_onehot", 32'(out_onehot), 32'h0);
        check("en0_valid",  32'(out_valid),  32'h0);
        check("en0_idx",    32'(out_idx),    32'h0);
        check("en0_done",   32'(scan_done),  32'h0);
        check("en0_ready",  32'(in_ready),   32'h0);

        // Async reset mid-scan at idx 5
        en = 1'b1; in_valid = 1'b0; mode = 1'b1; wrap = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        check("pre_rst_idx",    32'(out_idx),    32'h5);
        check("pre_rst_onehot", 32'(out_onehot), 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_onehot", 32'(out_onehot), 32'h0);
        check("async_valid",  32'(out_valid),  32'h0);
        check("async_idx",    32'(out_idx),    32'h0);
        check("async_done",   32'(scan_done),  32'h0);
        step(); step();
        rst_n = 1'b1;
        repeat (3) step();
        check("no_resume_onehot", 32'(out_onehot), 32'h0);
        check("no_resume_done",   32'(scan_done),  32'h0);

        // SEL_W=4, DWELL=1: one bit per cycle
        b_en = 1'b1; b_mode = 1'b1; b_wrap = 1'b0; b_start = 1'b1;
        step();
        b_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("d1_onehot", 32'(b_onehot), 32'(exp16[i]));
            check("d1_idx",    32'(b_idx),    32'(i));
            check("d1_inv",    32'($onehot(b_onehot)), 32'(b_valid));
            check("d1_nodone", 32'(b_done),   32'h0);
            step();
        end
        check("d1_end_onehot", 32'(b_onehot), 32'h0);
        check("d1_end_valid",  32'(b_valid),  32'h0);
        check("d1_done",       32'(b_done),   32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
